// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared timing constants, types and helpers for lcd_timing_gen
// Purpose: counter width, standard panel timing sets, the registered video
//          output bundle type and a packed-field extractor for window offsets.
// Ports:   none (package).
package lcd_timing_pkg;

   localparam int CNT_W   = 11;
   localparam int MAX_WIN = 4;
   localparam int PACK_W  = MAX_WIN * CNT_W;

   // 640x480 @ 60 Hz
   localparam int VGA_H_ACTIVE  = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_ACTIVE  = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   // 800x480 panel
   localparam int WVGA_H_ACTIVE = 800;
   localparam int WVGA_H_FP     = 40;
   localparam int WVGA_H_SYNC   = 48;
   localparam int WVGA_H_BP     = 40;
   localparam int WVGA_V_ACTIVE = 480;
   localparam int WVGA_V_FP     = 13;
   localparam int WVGA_V_SYNC   = 3;
   localparam int WVGA_V_BP     = 29;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic               hsync;
      logic               vsync;
      logic               de;
      logic [MAX_WIN-1:0] hit;
      cnt_t               px;
      cnt_t               py;
      logic               fs;
   } video_t;

   // Field i of a vector holding 11-bit values packed LSB-first.
   function automatic cnt_t win_field(input logic [PACK_W-1:0] vec, input int i);
      return vec[i*CNT_W +: CNT_W];
   endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// rtl/lcd_timing_gen_if.sv - video timing and framebuffer read bundle
// Purpose: groups the read-address stage and the delayed video outputs.
// Ports (master drives): rd_en, rd_addr, rd_win, lcd_hsync, lcd_vsync,
//          lcd_de, win_hit, px_x, px_y, frame_start.
interface lcd_timing_gen_if import lcd_timing_pkg::*; #(
   parameter int ADDR_W  = 16,
   parameter int NUM_WIN = 2
);
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [1:0]         rd_win;
   logic               lcd_hsync;
   logic               lcd_vsync;
   logic               lcd_de;
   logic [NUM_WIN-1:0] win_hit;
   cnt_t               px_x;
   cnt_t               px_y;
   logic               frame_start;

   modport master (output rd_en, rd_addr, rd_win, lcd_hsync, lcd_vsync,
                   lcd_de, win_hit, px_x, px_y, frame_start);
   modport slave  (input  rd_en, rd_addr, rd_win, lcd_hsync, lcd_vsync,
                   lcd_de, win_hit, px_x, px_y, frame_start);
endinterface

// File: rtl/lcd_win_addr.sv
// rtl/lcd_win_addr.sv - one image window: hit decode and line-base address accumulator
// Purpose: flags when the counters sit inside this window's active-area
//          rectangle and forms the local read address without a multiplier.
// Ports:   clk, rest (sync, active-high), en, h_cnt, v_cnt in;
//          hit, addr (combinational from counters and line_base) out.
module lcd_win_addr import lcd_timing_pkg::*; #(
   parameter int X_OFF   = 0,
   parameter int Y_OFF   = 0,
   parameter int IMG_W   = 200,
   parameter int IMG_H   = 164,
   parameter int H_BLANK = 160,
   parameter int V_BLANK = 45,
   parameter int H_TOTAL = 800,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              en,
   input  cnt_t              h_cnt,
   input  cnt_t              v_cnt,
   output logic              hit,
   output logic [ADDR_W-1:0] addr
);

   if (X_OFF + IMG_W > (1 << CNT_W) - 1 || Y_OFF + IMG_H > (1 << CNT_W) - 1) begin : g_bad_window
      $error("lcd_win_addr: window does not fit in 11-bit coordinates");
   end

   localparam cnt_t H_BL    = cnt_t'(H_BLANK);
   localparam cnt_t V_BL    = cnt_t'(V_BLANK);
   localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
   localparam cnt_t X_C     = cnt_t'(X_OFF);
   localparam cnt_t Y_C     = cnt_t'(Y_OFF);
   localparam cnt_t W_C     = cnt_t'(IMG_W);
   localparam cnt_t H_C     = cnt_t'(IMG_H);

   cnt_t              dx;
   cnt_t              dy;
   logic              in_col;
   logic              in_row;
   logic [ADDR_W-1:0] line_base;

   // Offsets into the window wrap to large values when left of / above it,
   // so a single unsigned compare against the size covers both edges.
   assign dx     = h_cnt - H_BL - X_C;
   assign dy     = v_cnt - V_BL - Y_C;
   assign in_col = (h_cnt >= H_BL) && (dx < W_C);
   assign in_row = (v_cnt >= V_BL) && (dy < H_C);
   assign hit    = in_col && in_row;
   assign addr   = line_base + ADDR_W'(dx);

   // Advances on every active row of the window, even when the window's
   // columns are clipped, so each row starts IMG_W past the previous one.
   always_ff @(posedge clk) begin
      if (rest) begin
         line_base <= '0;
      end else if (en) begin
         if (v_cnt == '0)
            line_base <= '0;
         else if (h_cnt == H_LAST && in_row)
            line_base <= line_base + ADDR_W'(IMG_W);
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised LCD sync generator with windowed framebuffer addressing
// Purpose: h/v counters, per-window address generators, lowest-index window
//          select (stage A) and the sync/de decode delayed RD_LAT cycles (stage B).
// Ports:   clk, rest (sync, active-high), en in; vid (master modport) carries
//          rd_en/rd_addr/rd_win and lcd_hsync/lcd_vsync/lcd_de/win_hit/px_x/px_y/frame_start.
module lcd_timing_gen import lcd_timing_pkg::*; #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int NUM_WIN  = 2,
   parameter int IMG_W    = 200,
   parameter int IMG_H    = 164,
   parameter logic [11*NUM_WIN-1:0] WIN_X = {11'd0, 11'd0},
   parameter logic [11*NUM_WIN-1:0] WIN_Y = {11'd200, 11'd0},
   parameter int ADDR_W   = 16,
   parameter int RD_LAT   = 1
) (
   input  logic clk,
   input  logic rest,
   input  logic en,
   lcd_timing_gen_if.master vid
);

   if (NUM_WIN < 1 || NUM_WIN > MAX_WIN || RD_LAT < 0 || RD_LAT > 3) begin : g_bad_params
      $error("lcd_timing_gen: NUM_WIN must be 1..4 and RD_LAT 0..3");
   end

   localparam int   H_BLANK = H_FP + H_SYNC + H_BP;
   localparam int   H_TOTAL = H_BLANK + H_ACTIVE;
   localparam int   V_BLANK = V_FP + V_SYNC + V_BP;
   localparam int   V_TOTAL = V_BLANK + V_ACTIVE;
   localparam cnt_t H_BL    = cnt_t'(H_BLANK);
   localparam cnt_t V_BL    = cnt_t'(V_BLANK);
   localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
   localparam cnt_t HFP_C   = cnt_t'(H_FP);
   localparam cnt_t HSY_C   = cnt_t'(H_SYNC);
   localparam cnt_t VFP_C   = cnt_t'(V_FP);
   localparam cnt_t VSY_C   = cnt_t'(V_SYNC);
   localparam logic HS_ACT  = (HS_POL != 0);
   localparam logic VS_ACT  = (VS_POL != 0);
   localparam logic [PACK_W-1:0] WX_ALL = PACK_W'(WIN_X);
   localparam logic [PACK_W-1:0] WY_ALL = PACK_W'(WIN_Y);
   localparam video_t VID_RST = '{hsync: !HS_ACT, vsync: !VS_ACT, default: '0};

   cnt_t              h_cnt;
   cnt_t              v_cnt;
   logic [NUM_WIN-1:0] hit;
   logic [ADDR_W-1:0] waddr [NUM_WIN];
   logic              sel_en;
   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_win;
   logic              ra_en;
   logic [ADDR_W-1:0] ra_addr;
   logic [1:0]        ra_win;
   video_t            dec;
   video_t            pipe [0:RD_LAT];

   always_ff @(posedge clk) begin
      if (rest) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
      lcd_win_addr #(
         .X_OFF   (int'(win_field(WX_ALL, w))),
         .Y_OFF   (int'(win_field(WY_ALL, w))),
         .IMG_W   (IMG_W),
         .IMG_H   (IMG_H),
         .H_BLANK (H_BLANK),
         .V_BLANK (V_BLANK),
         .H_TOTAL (H_TOTAL),
         .ADDR_W  (ADDR_W)
      ) u_win (
         .clk   (clk),
         .rest  (rest),
         .en    (en),
         .h_cnt (h_cnt),
         .v_cnt (v_cnt),
         .hit   (hit[w]),
         .addr  (waddr[w])
      );
   end

   // Scan from the top index down so the lowest hitting window wins.
   always_comb begin
      sel_en   = 1'b0;
      sel_addr = '0;
      sel_win  = '0;
      for (int w = NUM_WIN - 1; w >= 0; w--) begin
         if (hit[w]) begin
            sel_en   = 1'b1;
            sel_addr = waddr[w];
            sel_win  = 2'(w);
         end
      end
   end

   always_comb begin
      dec       = '0;
      dec.hsync = ((h_cnt - HFP_C) < HSY_C) ? HS_ACT : !HS_ACT;
      dec.vsync = ((v_cnt - VFP_C) < VSY_C) ? VS_ACT : !VS_ACT;
      dec.de    = (h_cnt >= H_BL) && (v_cnt >= V_BL);
      dec.hit   = MAX_WIN'(hit);
      if (dec.de) begin
         dec.px = h_cnt - H_BL;
         dec.py = v_cnt - V_BL;
      end
      dec.fs    = (h_cnt == H_BL) && (v_cnt == V_BL);
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         ra_en   <= 1'b0;
         ra_addr <= '0;
         ra_win  <= '0;
         for (int i = 0; i <= RD_LAT; i++)
            pipe[i] <= VID_RST;
      end else if (en) begin
         ra_en   <= sel_en;
         ra_addr <= sel_addr;
         ra_win  <= sel_win;
         pipe[0] <= dec;
         for (int i = 1; i <= RD_LAT; i++)
            pipe[i] <= pipe[i-1];
      end
   end

   assign vid.rd_en       = ra_en;
   assign vid.rd_addr     = ra_addr;
   assign vid.rd_win      = ra_win;
   assign vid.lcd_hsync   = pipe[RD_LAT].hsync;
   assign vid.lcd_vsync   = pipe[RD_LAT].vsync;
   assign vid.lcd_de      = pipe[RD_LAT].de;
   assign vid.win_hit     = pipe[RD_LAT].hit[NUM_WIN-1:0];
   assign vid.px_x        = pipe[RD_LAT].px;
   assign vid.px_y        = pipe[RD_LAT].py;
   assign vid.frame_start = pipe[RD_LAT].fs;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - self-checking bench for lcd_timing_gen
module tb_lcd_timing_gen;

   typedef struct packed {
      logic        rd_en;
      logic [15:0] rd_addr;
      logic [1:0]  rd_win;
      logic        hs;
      logic        vs;
      logic        de;
      logic [3:0]  hit;
      logic [10:0] px;
      logic [10:0] py;
      logic        fs;
   } exp_t;

   // instances: 0 small, 1 default-h, 2 overlap, 3 clip, 4 small/inverted/en-toggle
   string nm  [5] = '{"small", "dflt", "overlap", "clip", "small_en"};
   int hfp [5] = '{1, 16, 16, 16, 1};
   int hsy [5] = '{2, 96, 96, 96, 2};
   int hbp [5] = '{1, 48, 48, 48, 1};
   int ha  [5] = '{8, 640, 640, 640, 8};
   int vfp [5] = '{1, 1, 1, 1, 1};
   int vsy [5] = '{1, 1, 1, 1, 1};
   int vbp [5] = '{1, 1, 1, 1, 1};
   int va  [5] = '{4, 8, 8, 8, 4};
   int hpol[5] = '{1, 1, 1, 1, 0};
   int vpol[5] = '{1, 1, 1, 1, 0};
   int nw  [5] = '{2, 2, 2, 1, 3};
   int iw  [5] = '{3, 200, 200, 200, 4};
   int ih  [5] = '{2, 4, 4, 3, 2};
   int aw  [5] = '{16, 16, 16, 12, 16};
   int lat [5] = '{0, 1, 0, 3, 2};
   int wx  [5][4] = '{'{2, 6, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{600, 0, 0, 0}, '{0, 3, 5, 0}};
   int wy  [5][4] = '{'{1, 3, 0, 0}, '{0, 4, 0, 0}, '{0, 0, 0, 0}, '{2, 0, 0, 0}, '{0, 1, 2, 0}};

   logic clk = 1'b0;
   logic rest;
   logic en4;
   bit   started = 1'b0;
   bit   rst_q = 1'b0;
   int   k [5] = '{0, 0, 0, 0, 0};
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lcd_timing_gen_if #(.ADDR_W(16), .NUM_WIN(2)) v0 ();
   lcd_timing_gen_if #(.ADDR_W(16), .NUM_WIN(2)) v1 ();
   lcd_timing_gen_if #(.ADDR_W(16), .NUM_WIN(2)) v2 ();
   lcd_timing_gen_if #(.ADDR_W(12), .NUM_WIN(1)) v3 ();
   lcd_timing_gen_if #(.ADDR_W(16), .NUM_WIN(3)) v4 ();

   lcd_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(1), .NUM_WIN(2), .IMG_W(3), .IMG_H(2),
      .WIN_X({11'd6, 11'd2}), .WIN_Y({11'd3, 11'd1}), .ADDR_W(16), .RD_LAT(0))
      u0 (.clk(clk), .rest(rest), .en(1'b1), .vid(v0));

   lcd_timing_gen #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .NUM_WIN(2), .IMG_W(200),
      .IMG_H(4), .WIN_X({11'd0, 11'd0}), .WIN_Y({11'd4, 11'd0}), .ADDR_W(16), .RD_LAT(1))
      u1 (.clk(clk), .rest(rest), .en(1'b1), .vid(v1));

   lcd_timing_gen #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .NUM_WIN(2), .IMG_W(200),
      .IMG_H(4), .WIN_X({11'd0, 11'd0}), .WIN_Y({11'd0, 11'd0}), .ADDR_W(16), .RD_LAT(0))
      u2 (.clk(clk), .rest(rest), .en(1'b1), .vid(v2));

   lcd_timing_gen #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .NUM_WIN(1), .IMG_W(200),
      .IMG_H(3), .WIN_X(11'd600), .WIN_Y(11'd2), .ADDR_W(12), .RD_LAT(3))
      u3 (.clk(clk), .rest(rest), .en(1'b1), .vid(v3));

   lcd_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(0), .VS_POL(0), .NUM_WIN(3), .IMG_W(4), .IMG_H(2),
      .WIN_X({11'd5, 11'd3, 11'd0}), .WIN_Y({11'd2, 11'd1, 11'd0}), .ADDR_W(16), .RD_LAT(2))
      u4 (.clk(clk), .rest(rest), .en(en4), .vid(v4));

   exp_t act [5];
   assign act[0] = {v0.rd_en, 16'(v0.rd_addr), v0.rd_win, v0.lcd_hsync, v0.lcd_vsync, v0.lcd_de,
                    4'(v0.win_hit), v0.px_x, v0.px_y, v0.frame_start};
   assign act[1] = {v1.rd_en, 16'(v1.rd_addr), v1.rd_win, v1.lcd_hsync, v1.lcd_vsync, v1.lcd_de,
                    4'(v1.win_hit), v1.px_x, v1.px_y, v1.frame_start};
   assign act[2] = {v2.rd_en, 16'(v2.rd_addr), v2.rd_win, v2.lcd_hsync, v2.lcd_vsync, v2.lcd_de,
                    4'(v2.win_hit), v2.px_x, v2.px_y, v2.frame_start};
   assign act[3] = {v3.rd_en, 16'(v3.rd_addr), v3.rd_win, v3.lcd_hsync, v3.lcd_vsync, v3.lcd_de,
                    4'(v3.win_hit), v3.px_x, v3.px_y, v3.frame_start};
   assign act[4] = {v4.rd_en, 16'(v4.rd_addr), v4.rd_win, v4.lcd_hsync, v4.lcd_vsync, v4.lcd_de,
                    4'(v4.win_hit), v4.px_x, v4.px_y, v4.frame_start};

   function automatic bit inwin(input int c, input int w, input int x, input int y);
      return x >= 0 && y >= 0 && x >= wx[c][w] && x < wx[c][w] + iw[c] &&
             y >= wy[c][w] && y < wy[c][w] + ih[c];
   endfunction

   // Expected outputs after k enabled edges since reset: the counters stood at
   // linear pixel index k-1 for the address stage, k-1-RD_LAT for the video stage.
   function automatic exp_t model(input int c, input int kk);
      exp_t e;
      int ht, vt, hb, vb, s, h, v, x, y;
      e  = '0;
      ht = hfp[c] + hsy[c] + hbp[c] + ha[c];
      hb = ht - ha[c];
      vt = vfp[c] + vsy[c] + vbp[c] + va[c];
      vb = vt - va[c];
      e.hs = (hpol[c] == 0);
      e.vs = (vpol[c] == 0);
      s = kk - 1;
      if (s >= 0) begin
         h = s % ht; v = (s / ht) % vt; x = h - hb; y = v - vb;
         for (int w = nw[c] - 1; w >= 0; w--) begin
            if (inwin(c, w, x, y)) begin
               e.rd_en   = 1'b1;
               e.rd_win  = 2'(w);
               e.rd_addr = 16'(((y - wy[c][w]) * iw[c] + x - wx[c][w]) % (1 << aw[c]));
            end
         end
      end
      s = kk - 1 - lat[c];
      if (s >= 0) begin
         h = s % ht; v = (s / ht) % vt; x = h - hb; y = v - vb;
         e.hs = (h >= hfp[c] && h < hfp[c] + hsy[c]) ? (hpol[c] != 0) : (hpol[c] == 0);
         e.vs = (v >= vfp[c] && v < vfp[c] + vsy[c]) ? (vpol[c] != 0) : (vpol[c] == 0);
         e.de = (x >= 0) && (y >= 0);
         for (int w = 0; w < nw[c]; w++)
            e.hit[w] = inwin(c, w, x, y);
         if (e.de) begin
            e.px = 11'(x);
            e.py = 11'(y);
         end
         e.fs = (x == 0) && (y == 0);
      end
      return e;
   endfunction

   task automatic chk(input string name, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", name, a, e);
      end
   endtask

   task automatic chk_vec(input string name, input int kk, input exp_t a, input exp_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s k=%0d act rd_en=%b addr=%0d win=%0d hs=%b vs=%b de=%b hit=%b px=%0d py=%0d fs=%b exp rd_en=%b addr=%0d win=%0d hs=%b vs=%b de=%b hit=%b px=%0d py=%0d fs=%b",
            name, kk, a.rd_en, a.rd_addr, a.rd_win, a.hs, a.vs, a.de, a.hit, a.px, a.py, a.fs,
            e.rd_en, e.rd_addr, e.rd_win, e.hs, e.vs, e.de, e.hit, e.px, e.py, e.fs);
      end
   endtask

   always @(posedge clk) begin
      rst_q <= rest;
      for (int i = 0; i < 5; i++) begin
         if (rest)
            k[i] <= 0;
         else if (i != 4 || en4)
            k[i] <= k[i] + 1;
      end
   end

   // hand-computed event trackers
   int de0, hs0, vs0, fs0;
   int rise1, run1, rk1, rise3, run3;
   bit rd1_q, de1_q, de1_seen, w1_seen, ov_done, rd3_q;

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 5; i++)
            chk_vec(nm[i], k[i], act[i], model(i, k[i]));

         if (rst_q) begin
            chk("rst_hsync_inv_pol", v4.lcd_hsync, 1);
            chk("rst_vsync_inv_pol", v4.lcd_vsync, 1);
            chk("rst_hsync_pos_pol", v0.lcd_hsync, 0);
            chk("rst_rd_en", v1.rd_en, 0);
            chk("rst_rd_addr", v1.rd_addr, 0);
            chk("rst_de", v1.lcd_de, 0);
            de0 = 0; hs0 = 0; vs0 = 0; fs0 = 0;
            rise1 = 0; run1 = 0; rk1 = 0; rise3 = 0; run3 = 0;
            rd1_q = 0; de1_q = 0; de1_seen = 0; w1_seen = 0; ov_done = 0; rd3_q = 0;
         end else begin
            if (k[0] >= 1 && k[0] <= 84) begin
               de0 += int'(v0.lcd_de);
               hs0 += int'(v0.lcd_hsync);
               vs0 += int'(v0.lcd_vsync);
               fs0 += int'(v0.frame_start);
            end
            if (k[0] == 84) begin
               chk("small_de_per_frame", de0, 32);
               chk("small_hsync_per_frame", hs0, 14);
               chk("small_vsync_per_frame", vs0, 12);
               chk("small_frame_start_per_frame", fs0, 1);
            end

            if (v1.rd_en && !rd1_q) begin
               rise1++;
               if (rise1 == 1) begin
                  chk("dflt_row0_first_addr", v1.rd_addr, 0);
                  rk1 = k[1];
               end
               if (rise1 == 2)
                  chk("dflt_row1_first_addr", v1.rd_addr, 200);
               if (v1.rd_win == 2'd1 && !w1_seen) begin
                  w1_seen = 1;
                  chk("dflt_win1_restart_addr", v1.rd_addr, 0);
               end
            end
            if (!v1.rd_en && rd1_q && rise1 == 1)
               chk("dflt_row0_len", run1, 200);
            if (v1.rd_en)
               run1 = rd1_q ? run1 + 1 : 1;
            if (v1.lcd_de && !de1_q && !de1_seen) begin
               de1_seen = 1;
               chk("dflt_de_after_rd_en", k[1] - rk1, 1);
            end
            rd1_q = v1.rd_en;
            de1_q = v1.lcd_de;

            if (v2.lcd_de && !ov_done) begin
               ov_done = 1;
               chk("overlap_win_hit", v2.win_hit, 3);
               chk("overlap_rd_win", v2.rd_win, 0);
            end

            if (v3.rd_en && !rd3_q) begin
               rise3++;
               if (rise3 == 1) chk("clip_row0_first_addr", v3.rd_addr, 0);
               if (rise3 == 2) chk("clip_row1_first_addr", v3.rd_addr, 200);
            end
            if (!v3.rd_en && rd3_q && rise3 == 1)
               chk("clip_row0_len", run3, 40);
            if (v3.rd_en)
               run3 = rd3_q ? run3 + 1 : 1;
            rd3_q = v3.rd_en;
         end
      end
   end

   initial begin
      rest = 1'b1;
      en4  = 1'b1;
      @(posedge clk);
      #1 started = 1'b1;
      @(posedge clk);
      #1 rest = 1'b0;
      repeat (13000) begin
         @(posedge clk);
         #1 en4 = ~en4;
      end
      rest = 1'b1;
      @(posedge clk);
      #1 rest = 1'b0;
      en4 = 1'b1;
      repeat (9500) begin
         @(posedge clk);
         #1 en4 = ~en4;
      end
      @(negedge clk);
      chk("dflt_win1_seen", int'(w1_seen), 1);
      chk("dflt_de_seen", int'(de1_seen), 1);
      chk("overlap_seen", int'(ov_done), 1);
      chk("clip_rows_seen", int'(rise3 >= 2), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
